ppu_tile_engine: RTL

- Per-scanline background renderer. Fetches tile-map entries from tile RAM and pattern rows from pattern RAM, then writes 320 palette-indexed pixels into the back row RAM.
- Sits directly upstream of the row RAM. The HDMI output reads that row RAM after `rowram_swap`.
- Two instances, LAYER=0/1, each driving one VRAM port pair via the PPU's `vram_if`. The pixel mixer arbitrates the layers later.

---
 rtl/ppu_pkg.sv | 39 +++
 rtl/ppu_tile_pixel_sel.sv | 33 +++
 rtl/ppu_tile_engine.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types and constants for the PPU background tile path.
// Holds the tile-map entry layout, the row-RAM pixel type and the
// per-tile FSM state encoding used by ppu_tile_engine.
package ppu_pkg;

    // Screen and map geometry
    localparam int SCREEN_W  = 320;
    localparam int SCREEN_H  = 240;
    localparam int TILE_DIM  = 8;
    localparam int MAP_TILES = 64;

    // Row-RAM pixel: {layer, palette[4:0], color[3:0]}
    typedef logic [9:0] pixel_t;

    // One 16-bit tile-map entry; four of these are packed per tile RAM word
    typedef struct packed {
        logic       hflip;
        logic [4:0] palette;
        logic [9:0] pattern;
    } tile_entry_t;

    // Per-tile fetch/emit sequence
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH_T = 3'd1,
        ST_WAIT_T  = 3'd2,
        ST_FETCH_P = 3'd3,
        ST_WAIT_P  = 3'd4,
        ST_EMIT    = 3'd5,
        ST_DONE    = 3'd6
    } tile_state_e;

    // Map column for tile k of the line; the 6-bit sum wraps the 64-wide map
    function automatic logic [5:0] map_col(input logic [5:0] base_col,
                                           input logic [5:0] k);
        return base_col + k;
    endfunction

endpackage

// File: rtl/ppu_tile_pixel_sel.sv
// ppu_tile_pixel_sel: picks one 4-bit color out of a 64-bit pattern word.
// The word holds two 8-pixel rows; fy[0] chooses the upper or lower half.
// Optional macro PPU_TILE_HFLIP_EN: when defined, a set hflip mirrors the
// pixel order within the row; when undefined, hflip is ignored.
module ppu_tile_pixel_sel
    import ppu_pkg::*;
(
    input  logic [63:0] i_pat_word,
    input  logic        i_fy_lo,
    input  logic [2:0]  i_px_idx,
    input  logic        i_hflip,
    output logic [3:0]  o_color
);

`ifdef PPU_TILE_HFLIP_EN
    localparam logic HFLIP_ON = 1'b1;
`else
    localparam logic HFLIP_ON = 1'b0;
`endif

    logic [31:0] w_row;
    logic [2:0]  w_idx;

    // Odd fine rows live in the upper half of the word
    assign w_row = i_fy_lo ? i_pat_word[63:32] : i_pat_word[31:0];

    // Mirroring 0..7 is just inverting the 3-bit index
    assign w_idx = i_px_idx ^ {3{i_hflip & HFLIP_ON}};

    // Pixel n occupies nibble n of the selected row
    assign o_color = w_row[{w_idx, 2'b00} +: 4];

endmodule

// File: rtl/ppu_tile_engine.sv
// ppu_tile_engine: per-scanline background renderer for one layer.
// For each of TILES_PER_LINE tile columns it reads a tile-map word, then a
// pattern row, then emits eight pixels into the back row RAM. Pixels that
// fall left of the screen (fine X scroll) or right of SCREEN_W are dropped,
// so every row address 0..SCREEN_W-1 is written exactly once, ascending.
// Horizontal flip is gated by macro PPU_TILE_HFLIP_EN (in ppu_tile_pixel_sel).
//
// Handshake: line_start is a one-cycle request that is accepted only while
// idle (busy low); busy stays high from the cycle after acceptance until the
// cycle line_done pulses, which follows the final row-RAM write. Requests
// while busy are dropped, not queued.
module ppu_tile_engine
    import ppu_pkg::*;
#(
    parameter int LAYER          = 0,
    parameter int SCREEN_W       = 320,
    parameter int TILES_PER_LINE = 41
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        line_start,
    input  logic [7:0]  line_num,
    input  logic [8:0]  scroll_x,
    input  logic [8:0]  scroll_y,
    output logic        busy,
    output logic        line_done,
    output logic [10:0] tilram_addr,
    input  logic [63:0] tilram_rddata,
    output logic [11:0] patram_addr,
    input  logic [63:0] patram_rddata,
    output logic [8:0]  rr_wraddr,
    output logic [9:0]  rr_wrdata,
    output logic        rr_wren
);

    localparam logic              LAYER_BIT = 1'(LAYER);
    localparam logic [5:0]        LAST_K    = 6'(TILES_PER_LINE - 1);
    localparam logic signed [9:0] POS_LIMIT = 10'(SCREEN_W);

    tile_state_e r_state;
    logic        r_busy;
    logic        r_line_done;
    logic [10:0] r_tilram_addr;
    logic [11:0] r_patram_addr;
    logic [8:0]  r_rr_wraddr;
    pixel_t      r_rr_wrdata;
    logic        r_rr_wren;

    logic [8:0]  r_sx;       // latched horizontal scroll
    logic [8:0]  r_y;        // latched map row in pixels (line + scroll_y)
    logic [5:0]  r_k;        // tile index within the line
    logic [2:0]  r_i;        // pixel index within the tile
    logic [1:0]  r_ent_sel;  // which of the four entries in the tile word
    logic [4:0]  r_palette;
    logic        r_hflip;

    logic [5:0]        w_col;
    tile_entry_t       w_entry;
    logic signed [9:0] w_pos;
    logic              w_pos_ok;
    logic [3:0]        w_color;

    // Map column for the current tile, wrapping around the 64-tile map
    assign w_col = map_col(r_sx[8:3], r_k);

    // Entry col[1:0] of the returned tile word
    assign w_entry = tilram_rddata[{r_ent_sel, 4'b0000} +: 16];

    // Screen position of the current pixel; negative while fine scroll eats pixels
    assign w_pos    = $signed({1'b0, r_k, r_i}) - $signed({7'd0, r_sx[2:0]});
    assign w_pos_ok = ~w_pos[9] && (w_pos < POS_LIMIT);

    ppu_tile_pixel_sel u_pixel_sel (
        .i_pat_word (patram_rddata),
        .i_fy_lo    (r_y[0]),
        .i_px_idx   (r_i),
        .i_hflip    (r_hflip),
        .o_color    (w_color)
    );

    // Tile fetch/emit sequencer; every output is registered here
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_line_done   <= 1'b0;
            r_tilram_addr <= '0;
            r_patram_addr <= '0;
            r_rr_wraddr   <= '0;
            r_rr_wrdata   <= '0;
            r_rr_wren     <= 1'b0;
            r_sx          <= '0;
            r_y           <= '0;
            r_k           <= '0;
            r_i           <= '0;
            r_ent_sel     <= '0;
            r_palette     <= '0;
            r_hflip       <= 1'b0;
        end else begin
            r_line_done <= 1'b0;
            r_rr_wren   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (line_start) begin
                        r_sx    <= scroll_x;
                        r_y     <= {1'b0, line_num} + scroll_y;
                        r_k     <= '0;
                        r_i     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_FETCH_T;
                    end
                end
                ST_FETCH_T: begin
                    r_tilram_addr <= {LAYER_BIT, r_y[8:3], w_col[5:2]};
                    r_ent_sel     <= w_col[1:0];
                    r_state       <= ST_WAIT_T;
                end
                ST_WAIT_T: begin
                    r_state <= ST_FETCH_P;
                end
                ST_FETCH_P: begin
                    r_patram_addr <= {w_entry.pattern, r_y[2:1]};
                    r_palette     <= w_entry.palette;
                    r_hflip       <= w_entry.hflip;
                    r_state       <= ST_WAIT_P;
                end
                ST_WAIT_P: begin
                    r_i     <= '0;
                    r_state <= ST_EMIT;
                end
                ST_EMIT: begin
                    // Color 0 is written too; transparency is resolved downstream
                    if (w_pos_ok) begin
                        r_rr_wren   <= 1'b1;
                        r_rr_wraddr <= w_pos[8:0];
                        r_rr_wrdata <= {LAYER_BIT, r_palette, w_color};
                    end
                    r_i <= r_i + 3'd1;
                    if (r_i == 3'd7) begin
                        if (r_k == LAST_K) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_k     <= r_k + 6'd1;
                            r_state <= ST_FETCH_T;
                        end
                    end
                end
                ST_DONE: begin
                    r_busy      <= 1'b0;
                    r_line_done <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign line_done   = r_line_done;
    assign tilram_addr = r_tilram_addr;
    assign patram_addr = r_patram_addr;
    assign rr_wraddr   = r_rr_wraddr;
    assign rr_wrdata   = r_rr_wrdata;
    assign rr_wren     = r_rr_wren;

endmodule
